payment_collector: RTL

- Upstream stage of the change dispenser. Latches a validated price from the barcode/price stage, accumulates inserted coins/notes, and computes change (inserted − price) or a full refund on cancel.
- Presents the amount on moneyToGive for exactly one cycle, so the dispenser (which samples its amount input while idle) loads it once.
- Waits for the dispenser's done pulse (its noMoneyLeft) before accepting a new sale.

---
 rtl/payment_collector.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/payment_collector.sv
// Payment collector: latches a price, accumulates coins/notes, hands change or refund to the dispenser.
// Optional inactivity timeout in COLLECT is enabled by defining PAYMENT_TIMEOUT_EN.
//
// state       | meaning
// IDLE        | waiting for a valid price strobe
// COLLECT     | accumulating inserts against the latched price
// DISPENSE    | moneyToGive presents change/refund for this one cycle
// WAIT_DONE   | waiting for the dispenser's done pulse
// COMPLETE    | sale/refund pulse, insert total cleared
module payment_collector #(
  parameter int MAX_INSERT     = 30,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] price,
  input  logic       priceValid,
  input  logic       coin2In,
  input  logic       note10In,
  input  logic       note20In,
  input  logic       cancel,
  input  logic       dispenseDone,
  output logic [4:0] moneyToGive,
  output logic [5:0] inserted,
  output logic       insertReject,
  output logic       priceError,
  output logic       saleDone,
  output logic       refundDone,
  output logic       busy,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COLLECT   = 3'd1,
    S_DISPENSE  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_COMPLETE  = 3'd4
  } state_e;

  localparam logic [6:0] MAX_W = 7'(MAX_INSERT);

  state_e     state_q, state_d;
  logic [4:0] price_q, price_d;
  logic [5:0] inserted_q, inserted_d;
  logic [4:0] change_q, change_d;
  logic       sale_q, sale_d;
  logic [4:0] money_q;
  logic       reject_q, reject_d;
  logic       perr_q, perr_d;
  logic       sale_done_q, refund_done_q, busy_q;

  logic       any_ins, multi_ins, accept, timeout;
  logic [1:0] n_ins;
  logic [5:0] ins_val;
  logic [6:0] sum;
  logic       price_legal;

  assign n_ins       = {1'b0, coin2In} + {1'b0, note10In} + {1'b0, note20In};
  assign any_ins     = |n_ins;
  assign multi_ins   = n_ins > 2'd1;
  assign ins_val     = coin2In ? 6'd2 : (note10In ? 6'd10 : 6'd20);
  assign sum         = {1'b0, inserted_q} + {1'b0, ins_val};
  assign price_legal = (price != 5'd0) && !price[0] && (price <= 5'd28);

`ifdef PAYMENT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmr_q, tmr_d;

  // Any cancel or insert attempt outranks the timeout in the same cycle.
  assign timeout = (state_q == S_COLLECT) && (tmr_q == TW'(TIMEOUT_CYCLES)) &&
                   !cancel && !any_ins;

  always_comb begin
    tmr_d = '0;
    if (state_q == S_COLLECT && !accept) begin
      tmr_d = (tmr_q == TW'(TIMEOUT_CYCLES)) ? tmr_q : tmr_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) tmr_q <= '0;
    else       tmr_q <= tmr_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    price_d    = price_q;
    inserted_d = inserted_q;
    change_d   = change_q;
    sale_d     = sale_q;
    reject_d   = 1'b0;
    perr_d     = 1'b0;
    accept     = 1'b0;
    case (state_q)
      S_IDLE: begin
        reject_d = any_ins;
        if (priceValid) begin
          if (price_legal) begin
            price_d    = price;
            inserted_d = '0;
            state_d    = S_COLLECT;
          end else begin
            perr_d = 1'b1;
          end
        end
      end
      S_COLLECT: begin
        if (cancel || timeout) begin
          change_d = inserted_q[4:0];
          sale_d   = 1'b0;
          reject_d = any_ins;
          state_d  = S_DISPENSE;
        end else if (multi_ins) begin
          reject_d = 1'b1;
        end else if (any_ins) begin
          if (sum > MAX_W) begin
            reject_d = 1'b1;
          end else begin
            accept     = 1'b1;
            inserted_d = sum[5:0];
            if (sum >= {2'b00, price_q}) begin
              change_d = 5'(sum - {2'b00, price_q});
              sale_d   = 1'b1;
              state_d  = S_DISPENSE;
            end
          end
        end
      end
      S_DISPENSE:  state_d = (change_q != 5'd0) ? S_WAIT_DONE : S_COMPLETE;
      S_WAIT_DONE: begin
        reject_d = any_ins;
        if (dispenseDone) state_d = S_COMPLETE;
      end
      S_COMPLETE: begin
        inserted_d = '0;
        state_d    = S_IDLE;
      end
      default: begin
        inserted_d = '0;
        state_d    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      price_q       <= '0;
      inserted_q    <= '0;
      change_q      <= '0;
      sale_q        <= 1'b0;
      money_q       <= '0;
      reject_q      <= 1'b0;
      perr_q        <= 1'b0;
      sale_done_q   <= 1'b0;
      refund_done_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      price_q       <= price_d;
      inserted_q    <= inserted_d;
      change_q      <= change_d;
      sale_q        <= sale_d;
      // Amount is nonzero only while in DISPENSE so the dispenser loads it once.
      money_q       <= (state_d == S_DISPENSE) ? change_d : 5'd0;
      reject_q      <= reject_d;
      perr_q        <= perr_d;
      sale_done_q   <= (state_d == S_COMPLETE) && sale_d;
      refund_done_q <= (state_d == S_COMPLETE) && !sale_d;
      busy_q        <= (state_d != S_IDLE);
    end
  end

  assign moneyToGive  = money_q;
  assign inserted     = inserted_q;
  assign insertReject = reject_q;
  assign priceError   = perr_q;
  assign saleDone     = sale_done_q;
  assign refundDone   = refund_done_q;
  assign busy         = busy_q;
  assign state        = state_q;

endmodule
